// File: rtl/video_row_buffer_if.sv
// Decoder-write and scan-out-read signal bundle for video_row_buffer.
// slave = the row buffer, master = the decoder/display side driving it.
interface video_row_buffer_if;
  logic        o_video_start;
  logic [8:0]  i_video_column;
  logic [23:0] i_video_data;
  logic        i_video_data_valid;
  logic        i_line_start;
  logic        i_pixel_enable;
  logic [11:0] o_pixel_rgb;
  logic        o_pixel_valid;
  logic        o_fill_done;
  logic        o_underrun;
  logic        i_underrun_clear;

  modport slave (
    output o_video_start, o_pixel_rgb, o_pixel_valid, o_fill_done, o_underrun,
    input  i_video_column, i_video_data, i_video_data_valid, i_line_start,
           i_pixel_enable, i_underrun_clear
  );

  modport master (
    input  o_video_start, o_pixel_rgb, o_pixel_valid, o_fill_done, o_underrun,
    output i_video_column, i_video_data, i_video_data_valid, i_line_start,
           i_pixel_enable, i_underrun_clear
  );
endinterface

// File: rtl/video_row_buffer.sv
// Double-buffered line store: decoder fills one bank while scan-out reads the other.
// Build option ROW_BUFFER_UNDERRUN_FILL_EN: stale lines read as UNDERRUN_COLOR.
module video_row_buffer #(
  parameter int          WORDS          = 256,
  parameter logic [11:0] UNDERRUN_COLOR = 12'hF0F
) (
  input logic            i_master_clk,
  input logic            i_reset_n,
  video_row_buffer_if.slave bus
);
  localparam int AW = $clog2(WORDS);
  localparam int CW = AW + 2;
  localparam logic [CW-1:0] SAT = CW'(2 * WORDS);
`ifdef ROW_BUFFER_UNDERRUN_FILL_EN
  localparam bit FILL_EN = 1'b1;
`else
  localparam bit FILL_EN = 1'b0;
`endif

  typedef enum logic [1:0] {PRIME, FILLING, READY} state_t;

  state_t state;
  logic   wr_bank, disp_valid, stale, video_start, underrun;
  logic   last_wr, ls, complete, set_underrun, rd_en;
  logic   unused_col;

  assign unused_col   = bus.i_video_column[8];
  assign ls           = bus.i_line_start;
  assign last_wr      = bus.i_video_data_valid && (bus.i_video_column[7:0] == 8'(WORDS - 1));
  // A last write landing with the line start still counts as a complete fill.
  assign complete     = (state == READY) || ((state == FILLING) && last_wr);
  assign set_underrun = ls && (state == FILLING) && !last_wr;

  always_ff @(posedge i_master_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= PRIME;
      wr_bank     <= 1'b0;
      disp_valid  <= 1'b0;
      stale       <= 1'b0;
      video_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      video_start <= 1'b0;
      if (state == PRIME) begin
        state       <= FILLING;
        video_start <= 1'b1;
      end else if (ls && complete) begin
        wr_bank     <= ~wr_bank;
        disp_valid  <= 1'b1;
        stale       <= 1'b0;
        video_start <= 1'b1;
        state       <= FILLING;
      end else if (ls) begin
        stale <= 1'b1;
      end else if ((state == FILLING) && last_wr) begin
        state <= READY;
      end

      if (set_underrun)              underrun <= 1'b1;
      else if (bus.i_underrun_clear) underrun <= 1'b0;
    end
  end

  assign bus.o_video_start = video_start;
  assign bus.o_fill_done   = (state == READY);
  assign bus.o_underrun    = underrun;

  // Scan-out side: pixel counter, two pixels per stored word.
  logic [CW-1:0] pix_cnt;
  logic          pix_vld, pix_sel, pix_ok, pix_stale;
  logic [23:0]   rd_word;
  logic [11:0]   pix, rgb;

  assign rd_en = bus.i_pixel_enable && !ls;

  always_ff @(posedge i_master_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pix_cnt   <= '0;
      pix_vld   <= 1'b0;
      pix_sel   <= 1'b0;
      pix_ok    <= 1'b0;
      pix_stale <= 1'b0;
    end else begin
      pix_vld <= rd_en;
      if (ls)                         pix_cnt <= '0;
      else if (rd_en && pix_cnt != SAT) pix_cnt <= pix_cnt + 1'b1;
      if (rd_en) begin
        pix_sel   <= pix_cnt[0];
        pix_ok    <= disp_valid && (pix_cnt != SAT);
        pix_stale <= stale;
      end
    end
  end

  // Both banks in one array; the bank bit is the address MSB.
  logic [23:0] mem [2*WORDS];

  always_ff @(posedge i_master_clk) begin
    if (bus.i_video_data_valid)
      mem[{wr_bank, bus.i_video_column[AW-1:0]}] <= bus.i_video_data;
    if (rd_en)
      rd_word <= mem[{~wr_bank, pix_cnt[AW:1]}];
  end

  always_comb begin
    pix = pix_sel ? rd_word[23:12] : rd_word[11:0];
    rgb = '0;
    if (pix_vld && pix_ok)
      rgb = (FILL_EN && pix_stale) ? UNDERRUN_COLOR : pix;
  end

  assign bus.o_pixel_rgb   = rgb;
  assign bus.o_pixel_valid = pix_vld;
endmodule

// File: tb/tb_video_row_buffer.sv
// Scoreboard bench for video_row_buffer: expected pixels queued on enable, popped on o_pixel_valid.
module tb_video_row_buffer;
`ifdef ROW_BUFFER_UNDERRUN_FILL_EN
  localparam bit FILL = 1'b1;
`else
  localparam bit FILL = 1'b0;
`endif
  localparam logic [11:0] UCOL = 12'hF0F;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  video_row_buffer_if bus();
  video_row_buffer #(.WORDS(256), .UNDERRUN_COLOR(UCOL)) dut (
    .i_master_clk(clk), .i_reset_n(rst_n), .bus(bus));

  int checks = 0, errors = 0, start_cnt = 0;
  logic [11:0] exp_q[$];
  logic exp_vld;

  // reference model state
  logic [23:0] m_mem [2][256];
  bit m_wb, m_dvalid, m_stale, m_ready, m_ur;
  int m_cnt;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) exp_vld <= 1'b0;
    else        exp_vld <= bus.i_pixel_enable && !bus.i_line_start;

  always @(negedge clk) begin
    logic [11:0] e;
    if (bus.o_video_start === 1'b1) start_cnt++;
    checks++;
    if (bus.o_pixel_valid !== exp_vld) begin
      errors++;
      $display("FAIL pixel_valid t=%0t got %b want %b", $time, bus.o_pixel_valid, exp_vld);
    end
    if (bus.o_pixel_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pixel_unexpected t=%0t got %h", $time, bus.o_pixel_rgb);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (bus.o_pixel_rgb !== e) begin
          errors++;
          $display("FAIL pixel_rgb t=%0t got %h want %h", $time, bus.o_pixel_rgb, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic model_reset();
    m_wb = 0; m_dvalid = 0; m_stale = 0; m_ready = 0; m_ur = 0; m_cnt = 0;
    exp_q.delete();
  endtask

  // One clock of stimulus; the model advances with it.
  task automatic step(input bit wr, input int col, input logic [23:0] d,
                      input bit ls, input bit en, input bit clr);
    logic [23:0] w;
    logic [11:0] e;
    bit set;
    bus.i_video_data_valid = wr; bus.i_video_column = 9'(col); bus.i_video_data = d;
    bus.i_line_start = ls; bus.i_pixel_enable = en; bus.i_underrun_clear = clr;
    if (wr) begin
      m_mem[m_wb][col & 255] = d;
      if ((col & 255) == 255) m_ready = 1;
    end
    if (en && !ls) begin
      if (m_cnt >= 512 || !m_dvalid) e = 12'h000;
      else if (FILL && m_stale)      e = UCOL;
      else begin
        w = m_mem[~m_wb][m_cnt >> 1];
        e = m_cnt[0] ? w[23:12] : w[11:0];
      end
      exp_q.push_back(e);
      if (m_cnt < 512) m_cnt++;
    end
    set = ls && !m_ready;
    if (ls) begin
      m_cnt = 0;
      if (m_ready) begin m_wb = ~m_wb; m_dvalid = 1; m_stale = 0; m_ready = 0; end
      else begin m_ur = 1; m_stale = 1; end
    end
    if (clr && !set) m_ur = 0;
    tick();
    bus.i_video_data_valid = 0; bus.i_line_start = 0;
    bus.i_pixel_enable = 0; bus.i_underrun_clear = 0;
  endtask

  function automatic logic [23:0] word(input int base, input int c);
    return {12'(base + c + 1), 12'(base + c)};
  endfunction

  task automatic fill(input int base, input int first, input int last);
    for (int c = first; c <= last; c++) step(1, c, word(base, c), 0, 0, 0);
  endtask

  task automatic read(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, 0, 1, 0);
    repeat (2) tick();
  endtask

  task automatic test_reset();
    bus.i_video_data_valid = 0; bus.i_video_column = '0; bus.i_video_data = '0;
    bus.i_line_start = 0; bus.i_pixel_enable = 0; bus.i_underrun_clear = 0;
    model_reset();
    repeat (3) tick();
    checks++;
    if ({bus.o_video_start, bus.o_pixel_rgb, bus.o_pixel_valid, bus.o_fill_done, bus.o_underrun} !== 16'h0) begin
      errors++; $display("FAIL reset_outputs got %b want 0", {bus.o_video_start, bus.o_pixel_rgb,
        bus.o_pixel_valid, bus.o_fill_done, bus.o_underrun});
    end
    start_cnt = 0;
    rst_n = 1;
    @(negedge clk);
    checks++;
    if (bus.o_video_start !== 1'b0) begin errors++; $display("FAIL prime_no_start got %b want 0", bus.o_video_start); end
    tick();
    checks++;
    if (bus.o_video_start !== 1'b1) begin errors++; $display("FAIL start_pulse got %b want 1", bus.o_video_start); end
    repeat (6) tick();
    checks++;
    if (start_cnt !== 1) begin errors++; $display("FAIL start_once got %0d want 1", start_cnt); end
  endtask

  task automatic test_fill_read();
    int s0;
    fill(0, 0, 255);
    checks++;
    if (bus.o_fill_done !== 1'b1) begin errors++; $display("FAIL fill_done got %b want 1", bus.o_fill_done); end
    s0 = start_cnt;
    step(0, 0, '0, 1, 0, 0);
    checks++;
    if (bus.o_fill_done !== 1'b0) begin errors++; $display("FAIL fill_done_drop got %b want 0", bus.o_fill_done); end
    read(512);
    checks++;
    if (start_cnt !== s0 + 1) begin errors++; $display("FAIL swap_start got %0d want %0d", start_cnt, s0 + 1); end
  endtask

  task automatic test_underrun();
    int s0;
    fill(12'h100, 0, 99);
    s0 = start_cnt;
    step(0, 0, '0, 1, 0, 0);
    checks++;
    if (bus.o_underrun !== 1'b1) begin errors++; $display("FAIL underrun_set got %b want 1", bus.o_underrun); end
    read(512);
    checks++;
    if (start_cnt !== s0) begin errors++; $display("FAIL underrun_no_start got %0d want %0d", start_cnt, s0); end
    fill(12'h100, 100, 255);
    checks++;
    if (bus.o_fill_done !== 1'b1) begin errors++; $display("FAIL refill_done got %b want 1", bus.o_fill_done); end
    step(0, 0, '0, 1, 0, 0);
    read(40);
    checks++;
    if (bus.o_underrun !== m_ur) begin errors++; $display("FAIL underrun_sticky got %b want %b", bus.o_underrun, m_ur); end
    step(0, 0, '0, 0, 0, 1);
    checks++;
    if (bus.o_underrun !== 1'b0) begin errors++; $display("FAIL underrun_clear got %b want 0", bus.o_underrun); end
  endtask

  task automatic test_last_write_with_start();
    int s0;
    fill(12'h200, 0, 254);
    s0 = start_cnt;
    step(1, 255, word(12'h200, 255), 1, 0, 0);
    tick();
    checks++;
    if (bus.o_underrun !== 1'b0) begin errors++; $display("FAIL concurrent_underrun got %b want 0", bus.o_underrun); end
    checks++;
    if (start_cnt !== s0 + 1) begin errors++; $display("FAIL concurrent_start got %0d want %0d", start_cnt, s0 + 1); end
  endtask

  task automatic test_saturation();
    read(600);
    step(0, 0, '0, 1, 1, 0);   // enable dropped, line start while FILLING
    checks++;
    if (bus.o_underrun !== m_ur) begin errors++; $display("FAIL sat_underrun got %b want %b", bus.o_underrun, m_ur); end
    read(8);
  endtask

  task automatic test_reset_mid_fill();
    int s0;
    fill(12'h300, 0, 49);
    step(0, 0, '0, 0, 1, 0);
    #6 rst_n = 0;
    model_reset();
    #1;
    checks++;
    if ({bus.o_video_start, bus.o_pixel_rgb, bus.o_pixel_valid, bus.o_fill_done, bus.o_underrun} !== 16'h0) begin
      errors++; $display("FAIL async_reset got %b want 0", {bus.o_video_start, bus.o_pixel_rgb,
        bus.o_pixel_valid, bus.o_fill_done, bus.o_underrun});
    end
    tick();
    rst_n = 1;
    s0 = start_cnt;
    repeat (4) tick();
    checks++;
    if (start_cnt !== s0 + 1) begin errors++; $display("FAIL reprime_start got %0d want %0d", start_cnt, s0 + 1); end
    read(10);
    step(0, 0, '0, 1, 0, 1);   // clear and new underrun together
    checks++;
    if (bus.o_underrun !== 1'b1) begin errors++; $display("FAIL set_wins got %b want 1", bus.o_underrun); end
    read(4);
    fill(12'h300, 0, 255);
    step(0, 0, '0, 1, 0, 0);
    read(20);
    checks++;
    if (bus.o_underrun !== m_ur) begin errors++; $display("FAIL final_underrun got %b want %b", bus.o_underrun, m_ur); end
  endtask

  initial begin
    test_reset();
    test_fill_read();
    test_underrun();
    test_last_write_with_start();
    test_saturation();
    test_reset_mid_fill();
    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL pixels_missing got %0d left want 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
